// File: rtl/spi_tx_fifo_slave.sv
// spi_tx_fifo_slave: buffered SPI slave transmitter, MSB-first, CPOL=0/CPHA=0
module spi_tx_fifo_slave #(
   parameter int                DATA_W    = 16,
   parameter int                DEPTH     = 1024,
   parameter bit                BURST     = 1'b0,
   parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   cs_n,
   input  logic                   sclk,
   output logic                   sdo,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   frame_done,
   output logic                   overflow,
   output logic                   underrun,
   input  logic                   clr_err
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int CW = $clog2(DATA_W + 1);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
   state_t            state, state_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [DATA_W-1:0] shift_reg;
   logic [CW-1:0]     bit_cnt;
   logic              cs_s1, cs_s2, cs_d, sclk_s1, sclk_s2, sclk_d;
   logic              cs_rise, cs_fall, sclk_fall;
   logic              load_now, shift_now, sdo_nxt, take, wr_ok;
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   assign full      = level == LW'(DEPTH);
   assign empty     = level == '0;
   assign cs_rise   = cs_s2 & ~cs_d;
   assign cs_fall   = ~cs_s2 & cs_d;
   assign sclk_fall = ~sclk_s2 & sclk_d;
   assign take      = load_now & ~empty;
   assign wr_ok     = wr_en & (~full | take);
   // two-flop synchronisers plus an edge-detect stage for the SPI pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {cs_s1, cs_s2, cs_d}       <= 3'b111;
         {sclk_s1, sclk_s2, sclk_d} <= 3'b000;
      end else begin
         {cs_s1, cs_s2, cs_d}       <= {cs_n, cs_s1, cs_s2};
         {sclk_s1, sclk_s2, sclk_d} <= {sclk, sclk_s1, sclk_s2};
      end
   end
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end
   // next state: a chip-select release returns to IDLE from anywhere
   always_comb begin
      state_nxt = state;
      if (cs_rise)                      state_nxt = IDLE;
      else if (state == IDLE && cs_fall) state_nxt = LOAD;
      else if (state == LOAD)            state_nxt = SHIFT;
   end
   // FSM outputs: load/shift strobes and the next serial bit; cs_n rising beats sclk
   always_comb begin
      load_now  = !cs_rise && (state == LOAD ||
                  (BURST && state == SHIFT && sclk_fall && bit_cnt == CW'(DATA_W - 1)));
      shift_now = !cs_rise && !load_now && state == SHIFT && sclk_fall && bit_cnt != CW'(DATA_W);
      sdo_nxt   = !cs_rise && state == SHIFT && bit_cnt != CW'(DATA_W) && shift_reg[DATA_W-1];
   end
   // word storage; a read of the slot being overwritten returns the old word
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end
   // pointers, level and sticky error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (take)  rd_ptr <= ptr_inc(rd_ptr);
         level    <= level + LW'(wr_ok) - LW'(take);
         overflow <= !clr_err && (overflow || (wr_en && full && !take));
         underrun <= !clr_err && (underrun || (load_now && empty));
      end
   end
   // shift register, bit counter and registered serial outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg  <= '0;
         bit_cnt    <= '0;
         sdo        <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         if (load_now) begin
            shift_reg <= empty ? IDLE_WORD : mem[rd_ptr];
            bit_cnt   <= '0;
         end else if (shift_now) begin
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
            bit_cnt   <= bit_cnt + 1'b1;
         end
         sdo        <= sdo_nxt;
         frame_done <= cs_rise;
      end
   end
endmodule

// File: tb/tb_spi_tx_fifo_slave.sv
// tb_spi_tx_fifo_slave: scoreboard and vector-table bench for spi_tx_fifo_slave
module tb_spi_tx_fifo_slave;
   localparam int DW = 16;
   localparam int DP = 8;
   typedef struct {
      logic [DW-1:0] data;
      logic [3:0]    lvl;
      logic          fl;
      logic          ov;
   } wvec_t;
   logic          clk = 0, rst_n = 0, wr_en0 = 0, wr_en1 = 0, cs0 = 1, cs1 = 1, sclk = 0, clr_err = 0;
   logic [DW-1:0] wr_data = '0;
   logic          sdo0, sdo1, full0, full1, empty0, empty1, fd0, fd1, ovf0, ovf1, und0, und1;
   logic [3:0]    lvl0, lvl1;
   int            errors = 0, checks = 0, fd0_cnt = 0;
   logic [DW-1:0] q0[$], q1[$];
   wvec_t         tbl[9];

   spi_tx_fifo_slave #(.DATA_W(DW), .DEPTH(DP), .BURST(1'b0), .IDLE_WORD(16'h1234)) u0 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .wr_data(wr_data), .cs_n(cs0), .sclk(sclk),
      .sdo(sdo0), .full(full0), .empty(empty0), .level(lvl0), .frame_done(fd0),
      .overflow(ovf0), .underrun(und0), .clr_err(clr_err));
   spi_tx_fifo_slave #(.DATA_W(DW), .DEPTH(DP), .BURST(1'b1), .IDLE_WORD(16'h0000)) u1 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_data(wr_data), .cs_n(cs1), .sclk(sclk),
      .sdo(sdo1), .full(full1), .empty(empty1), .level(lvl1), .frame_done(fd1),
      .overflow(ovf1), .underrun(und1), .clr_err(clr_err));

   always #5 clk = ~clk;
   always @(posedge clk) if (fd0) fd0_cnt++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wr(input int d, input logic [DW-1:0] w);
      @(negedge clk);
      wr_data = w;
      if (d == 0) wr_en0 = 1; else wr_en1 = 1;
      @(negedge clk);
      wr_en0 = 0;
      wr_en1 = 0;
      if (d == 0) begin if (q0.size() < DP) q0.push_back(w); end
      else begin if (q1.size() < DP) q1.push_back(w); end
   endtask

   function automatic logic [DW-1:0] pop0();
      return q0.size() > 0 ? q0.pop_front() : 16'h1234;
   endfunction

   function automatic logic [DW-1:0] pop1();
      return q1.size() > 0 ? q1.pop_front() : 16'h0000;
   endfunction

   // master frame; the last sclk fall coincides with cs_n release
   task automatic frame(input int d, input int nbits, input bit wr_load, input logic [DW-1:0] w,
                        output logic [63:0] bits);
      bits = '0;
      @(negedge clk);
      if (d == 0) cs0 = 0; else cs1 = 0;
      repeat (3) @(negedge clk);
      if (wr_load) begin
         wr_data = w;
         wr_en0  = 1;
         @(negedge clk);
         wr_en0 = 0;
      end
      repeat (8) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         bits = {bits[62:0], (d == 0) ? sdo0 : sdo1};
         sclk = 1;
         repeat (8) @(negedge clk);
         sclk = 0;
         if (i == nbits - 1) begin cs0 = 1; cs1 = 1; end
         repeat (8) @(negedge clk);
      end
      cs0 = 1;
      cs1 = 1;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      logic [63:0]   bits;
      logic [DW-1:0] e, e1, e2;
      int            n;
      for (int i = 0; i < 9; i++) begin
         tbl[i].data = DW'(16'h3C05 + i * 16'h1111);
         tbl[i].lvl  = 4'(i < DP ? i + 1 : DP);
         tbl[i].fl   = i >= DP - 1;
         tbl[i].ov   = i == DP;
      end
      repeat (3) @(negedge clk);
      chk("rst_sdo", sdo0, 0);
      chk("rst_level", lvl0, 0);
      chk("rst_empty", empty0, 1);
      chk("rst_full", full0, 0);
      chk("rst_frame_done", fd0, 0);
      chk("rst_overflow", ovf0, 0);
      chk("rst_underrun", und0, 0);
      rst_n = 1;
      repeat (2) @(negedge clk);
      wr(0, 16'hA5C3);
      wr(0, 16'h0F0F);
      chk("level_two", lvl0, 2);
      n = fd0_cnt;
      e = pop0();
      frame(0, 16, 0, '0, bits);
      chk("frame_a5c3", bits, {48'b0, e});
      chk("frame_done_once", fd0_cnt - n, 1);
      chk("level_one", lvl0, 1);
      e = pop0();
      frame(0, 16, 0, '0, bits);
      chk("frame_0f0f", bits, {48'b0, e});
      chk("drained_empty", empty0, 1);
      chk("underrun_clear", und0, 0);
      e = pop0();
      frame(0, 16, 0, '0, bits);
      chk("idle_word", bits, {48'b0, e});
      chk("underrun_set", und0, 1);
      chk("underrun_level", lvl0, 0);
      @(negedge clk) clr_err = 1;
      @(negedge clk) clr_err = 0;
      chk("underrun_cleared", und0, 0);
      foreach (tbl[i]) begin
         wr(0, tbl[i].data);
         chk($sformatf("fill%0d_level", i), lvl0, tbl[i].lvl);
         chk($sformatf("fill%0d_full", i), full0, tbl[i].fl);
         chk($sformatf("fill%0d_ovf", i), ovf0, tbl[i].ov);
      end
      @(negedge clk) clr_err = 1;
      @(negedge clk) clr_err = 0;
      chk("overflow_cleared", ovf0, 0);
      chk("still_full", full0, 1);
      e = pop0();
      q0.push_back(16'hBEEF);
      frame(0, 16, 1, 16'hBEEF, bits);
      chk("full_load_word", bits, {48'b0, e});
      chk("full_load_level", lvl0, DP);
      chk("full_load_no_ovf", ovf0, 0);
      n = 0;
      while (q0.size() > 0) begin
         e = pop0();
         frame(0, 16, 0, '0, bits);
         chk($sformatf("drain%0d", n), bits, {48'b0, e});
         n++;
      end
      chk("drain_tail_beef", e, 16'hBEEF);
      chk("drain_level", lvl0, 0);
      wr(0, 16'hB6D1);
      wr(0, 16'h4E27);
      e = pop0();
      frame(0, 5, 0, '0, bits);
      chk("short_frame", bits, {48'b0, e >> 11});
      e = pop0();
      frame(0, 16, 0, '0, bits);
      chk("after_short", bits, {48'b0, e});
      wr(1, 16'h0001);
      wr(1, 16'h8000);
      wr(1, 16'hFFFF);
      e = pop1();
      e1 = pop1();
      e2 = pop1();
      frame(1, 48, 0, '0, bits);
      chk("burst_stream", bits, {16'b0, e, e1, e2});
      chk("burst_level", lvl1, 0);
      chk("burst_underrun", und1, 0);
      wr(0, 16'hFFFF);
      void'(pop0());
      cs0 = 0;
      repeat (11) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         sclk = 1;
         repeat (8) @(negedge clk);
         sclk = 0;
         repeat (8) @(negedge clk);
      end
      chk("midframe_sdo_high", sdo0, 1);
      #2 rst_n = 0;
      #1;
      chk("async_rst_sdo", sdo0, 0);
      chk("async_rst_level", lvl0, 0);
      chk("async_rst_empty", empty0, 1);
      chk("async_rst_fd", fd0, 0);
      cs0 = 1;
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
